instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_t : fetch controller state encoding (IDLE, FETCH, FAULT)
//   INSTR_BYTES   : size of one instruction word in bytes (PC increment)
//   NOP_INSTR     : instruction presented to decode when nothing is buffered
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO buffering fetched {pc, instruction} pairs.
// Ports:
//   clk   in  1           rising-edge clock
//   rst   in  1           asynchronous active-high reset (empties the FIFO)
//   flush in  1           synchronous flush; wins over push and pop
//   push  in  1           write wdata (ignored when full without a same-edge pop)
//   pop   in  1           drop head entry (ignored when empty)
//   wdata in  DATA_WIDTH  entry to write
//   rdata out DATA_WIDTH  head entry (meaningless while empty)
//   full  out 1           DEPTH entries stored
//   empty out 1           no entries stored
module fetch_fifo #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign rdata = mem_r[rd_ptr_r];

    // Qualify requests: a push into a full FIFO is only legal alongside a pop.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
    end

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch unit with redirect support and a
// small decoupling buffer towards decode.
// Build option: define INSTR_FETCH_MISALIGN_FAULT_EN to trap misaligned
// redirect targets in the FAULT state; otherwise targets are aligned down.
// Ports:
//   clk               in  1           rising-edge clock
//   rst               in  1           asynchronous active-high reset
//   imem_addr_out     out ADDR_WIDTH  fetch byte address (current pc)
//   imem_instr_in     in  32          instruction at imem_addr_out, same cycle
//   redirect_valid_in in  1           branch/jump redirect request
//   redirect_pc_in    in  ADDR_WIDTH  redirect target
//   instr_out         out 32          buffered head instruction (NOP if empty)
//   pc_out            out ADDR_WIDTH  address of instr_out (0 if empty)
//   valid_out         out 1           instr_out/pc_out valid
//   ready_in          in  1           decode accepts the head this edge
//   fault_out         out 1           misaligned redirect trapped
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    input  logic [31:0]           imem_instr_in,
    input  logic                  redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
    output logic [31:0]           instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  fault_out
);

    localparam int ENTRY_W = ADDR_WIDTH + 32;

    fetch_state_t          state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  misalign_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic [ENTRY_W-1:0]    head_s;

    // Redirect target handling: trap or silently align down.
    always_comb begin
`ifdef INSTR_FETCH_MISALIGN_FAULT_EN
        target_s   = redirect_pc_in;
        misalign_s = |redirect_pc_in[1:0];
`else
        target_s   = redirect_pc_in & ~ADDR_WIDTH'(INSTR_BYTES - 1);
        misalign_s = 1'b0;
`endif
    end

    // A redirect cancels both the same-edge pop and push.
    always_comb begin
        pop_s  = ~empty_s & ready_in & ~redirect_valid_in;
        push_s = (state_r == FETCH) & ~redirect_valid_in & (~full_s | pop_s);
    end

    // Fetch controller: redirect overrides everything, then per-state behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
        end else if (redirect_valid_in) begin
            if (misalign_s) begin
                state_r <= FAULT;
                pc_r    <= pc_r;
            end else begin
                state_r <= FETCH;
                pc_r    <= target_s;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (push_s) begin
                        pc_r <= pc_r + ADDR_WIDTH'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    state_r <= FAULT;
                end
                default: begin
                    state_r <= IDLE;
                    pc_r    <= RESET_PC;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid_in),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({pc_r, imem_instr_in}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign imem_addr_out = pc_r;
    assign valid_out     = ~empty_s;
    assign instr_out     = empty_s ? NOP_INSTR : head_s[31:0];
    assign pc_out        = empty_s ? '0 : head_s[ENTRY_W-1:32];

`ifdef INSTR_FETCH_MISALIGN_FAULT_EN
    assign fault_out = (state_r == FAULT);
`else
    assign fault_out = 1'b0;
`endif

endmodule
